// File: rtl/intr_ctrl.sv
// Interrupt controller: latches, masks and prioritises device lines [7:2],
// presents one request to the CPU and tracks it from acknowledge until ERET.
module intr_ctrl #(
    parameter int               N_SRC    = 6,
    parameter logic [N_SRC-1:0] MASK_RST = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       dev_addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [N_SRC-1:0] hw_intr_in,
    output logic             intr_req,
    output logic [2:0]       intr_id,
    input  logic             intr_ack,
    input  logic             eret
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SERV = 2'd2;

    logic [1:0]       state;
    logic [N_SRC-1:0] pend, mask, mode, in_prev;
    logic [2:0]       id_q, srv_id;

    logic [N_SRC-1:0] pend_n, mask_n, w1c, ack_clr, lat_oh, set_e;
    logic [N_SRC-1:0] pm;
    logic             win_vld, held, ack_ok;
    logic [2:0]       win_id;
    logic             wr_pend, wr_mask, wr_mode;
    logic             unused_wd;

    assign unused_wd = ^{wd[31:N_SRC+2], wd[1:0]};

    assign wr_pend = sel && we && (dev_addr == 2'd0);
    assign wr_mask = sel && we && (dev_addr == 2'd1);
    assign wr_mode = sel && we && (dev_addr == 2'd2);

    assign lat_oh  = {{(N_SRC-1){1'b0}}, 1'b1} << (id_q - 3'd2);
    assign ack_ok  = (state == REQ) && intr_ack;
    assign ack_clr = ack_ok ? lat_oh : '0;
    assign w1c     = wr_pend ? wd[N_SRC+1:2] : '0;
    assign set_e   = hw_intr_in & ~in_prev;

    // Edge sources: set beats any clear; level sources just follow the line.
    assign pend_n = (mode & (set_e | (pend & ~w1c & ~ack_clr)))
                  | (~mode & hw_intr_in);
    assign mask_n = wr_mask ? wd[N_SRC+1:2] : mask;
    assign held   = |(pend_n & mask_n & lat_oh);
    assign pm     = pend & mask;

    always_comb begin
        win_vld = 1'b0;
        win_id  = 3'd0;
        for (int i = 0; i < N_SRC; i++) begin
            if (pm[i]) begin
                win_vld = 1'b1;
                win_id  = 3'(i + 2);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            mask    <= MASK_RST;
            mode    <= '1;
            in_prev <= '0;
        end else begin
            pend    <= pend_n;
            mask    <= mask_n;
            in_prev <= hw_intr_in;
            if (wr_mode) mode <= wd[N_SRC+1:2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            id_q   <= 3'd0;
            srv_id <= 3'd0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    state <= REQ;
                    id_q  <= win_id;
                end
                REQ: if (intr_ack) begin
                    state  <= SERV;
                    srv_id <= id_q;
                end else if (!held) begin
                    state <= IDLE;
                end
                SERV: if (eret) begin
                    state  <= IDLE;
                    srv_id <= 3'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign intr_req = (state == REQ);
    assign intr_id  = (state == REQ) ? id_q : 3'd0;

    always_comb begin
        rd = 32'd0;
        case (dev_addr)
            2'd0: rd = {{(30-N_SRC){1'b0}}, pend, 2'b00};
            2'd1: rd = {{(30-N_SRC){1'b0}}, mask, 2'b00};
            2'd2: rd = {{(30-N_SRC){1'b0}}, mode, 2'b00};
            default: rd = {state == SERV, 28'd0, srv_id};
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: bus access, priority, no-preempt,
// level mode, mask drop and asynchronous reset.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, we;
    logic [1:0]  dev_addr;
    logic [31:0] wd, rd;
    logic [5:0]  hw_intr_in;
    logic        intr_req;
    logic [2:0]  intr_id;
    logic        intr_ack, eret;

    int n_chk  = 0;
    int n_fail = 0;

    intr_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .we         (we),
        .dev_addr   (dev_addr),
        .wd         (wd),
        .rd         (rd),
        .hw_intr_in (hw_intr_in),
        .intr_req   (intr_req),
        .intr_id    (intr_id),
        .intr_ack   (intr_ack),
        .eret       (eret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; dev_addr = a; wd = d;
        tick();
        sel = 1'b0; we = 1'b0; wd = 32'd0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
        dev_addr = a;
        #1;
        v = rd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sel = 1'b0; we = 1'b0; dev_addr = 2'd0; wd = 32'd0;
        hw_intr_in = 6'd0; intr_ack = 1'b0; eret = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        n_chk++;
        if (intr_req !== 1'b0 || intr_id !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_req: req=%0b id=%0d want 0/0", intr_req, intr_id);
        end
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL rst_pend: got %h want 0", v);
        end
        rd_reg(2'd1, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL rst_mask: got %h want 0", v);
        end
        rd_reg(2'd2, v); n_chk++;
        if (v !== 32'hFC) begin
            n_fail++; $display("FAIL rst_mode: got %h want fc", v);
        end
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL rst_stat: got %h want 0", v);
        end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'h84);
        hw_intr_in[0] = 1'b1;
        tick();
        hw_intr_in[0] = 1'b0;
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h04 || intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pend: pend=%h req=%0b want 04/0", v, intr_req);
        end
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd2) begin
            n_fail++;
            $display("FAIL basic_req: req=%0b id=%0d want 1/2", intr_req, intr_id);
        end
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h8000_0002) begin
            n_fail++; $display("FAIL basic_stat: got %h want 80000002", v);
        end
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h0 || intr_req !== 1'b0 || intr_id !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_serv: pend=%h req=%0b id=%0d want 0/0/0",
                     v, intr_req, intr_id);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL basic_eret: stat=%h want 0", v);
        end
    endtask

    task automatic test_priority();
        do_reset();
        wr(2'd1, 32'hFC);
        hw_intr_in = 6'b010010;
        tick();
        hw_intr_in = 6'd0;
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd6) begin
            n_fail++;
            $display("FAIL prio_first: req=%0b id=%0d want 1/6", intr_req, intr_id);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd3) begin
            n_fail++;
            $display("FAIL prio_second: req=%0b id=%0d want 1/3", intr_req, intr_id);
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        wr(2'd1, 32'hFC);
        hw_intr_in[1] = 1'b1;
        tick();
        hw_intr_in[1] = 1'b0;
        tick();
        hw_intr_in[5] = 1'b1;
        tick();
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd3) begin
            n_fail++;
            $display("FAIL preempt_hold: req=%0b id=%0d want 1/3", intr_req, intr_id);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd7) begin
            n_fail++;
            $display("FAIL preempt_next: req=%0b id=%0d want 1/7", intr_req, intr_id);
        end
        hw_intr_in[5] = 1'b0;
    endtask

    task automatic test_level();
        logic [31:0] v;
        do_reset();
        wr(2'd2, 32'hEC);
        wr(2'd1, 32'h10);
        hw_intr_in[2] = 1'b1;
        tick();
        wr(2'd0, 32'h10);
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h10 || intr_id !== 3'd4) begin
            n_fail++;
            $display("FAIL level_w1c: pend=%h id=%0d want 10/4", v, intr_id);
        end
        intr_ack = 1'b1; tick(); intr_ack = 1'b0;
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h10) begin
            n_fail++; $display("FAIL level_ack: pend=%h want 10", v);
        end
        hw_intr_in[2] = 1'b0;
        tick();
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL level_drop: pend=%h want 0", v);
        end
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic test_mask_drop();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'h20);
        hw_intr_in[3] = 1'b1;
        tick();
        hw_intr_in[3] = 1'b0;
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd5) begin
            n_fail++;
            $display("FAIL mdrop_req: req=%0b id=%0d want 1/5", intr_req, intr_id);
        end
        wr(2'd1, 32'h0);
        n_chk++;
        if (intr_req !== 1'b0 || intr_id !== 3'd0) begin
            n_fail++;
            $display("FAIL mdrop_idle: req=%0b id=%0d want 0/0", intr_req, intr_id);
        end
        wr(2'd1, 32'h20);
        tick();
        n_chk++;
        if (intr_req !== 1'b1 || intr_id !== 3'd5) begin
            n_fail++;
            $display("FAIL mdrop_rereq: req=%0b id=%0d want 1/5", intr_req, intr_id);
        end
        intr_ack = 1'b1;
        wr(2'd1, 32'h0);
        intr_ack = 1'b0;
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h8000_0005 || intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL mdrop_ackwin: stat=%h req=%0b want 80000005/0", v, intr_req);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        reset = 1'b1;
        #1;
        n_chk++;
        if (intr_req !== 1'b0) begin
            n_fail++; $display("FAIL areset_req: got %0b want 0", intr_req);
        end
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL areset_stat: got %h want 0", v);
        end
        rd_reg(2'd1, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL areset_mask: got %h want 0", v);
        end
        rd_reg(2'd2, v); n_chk++;
        if (v !== 32'hFC) begin
            n_fail++; $display("FAIL areset_mode: got %h want fc", v);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        hw_intr_in[0] = 1'b1;
        wr(2'd0, 32'h04);
        hw_intr_in[0] = 1'b0;
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h04) begin
            n_fail++; $display("FAIL setwin: pend=%h want 04", v);
        end
        intr_ack = 1'b1; eret = 1'b1;
        tick();
        intr_ack = 1'b0; eret = 1'b0;
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h04 || intr_req !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: pend=%h req=%0b want 04/0", v, intr_req);
        end
        wr(2'd0, 32'h04);
        rd_reg(2'd0, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL w1c: pend=%h want 0", v);
        end
        wr(2'd1, 32'hFFFF_FFFF);
        rd_reg(2'd1, v); n_chk++;
        if (v !== 32'hFC) begin
            n_fail++; $display("FAIL mask_bits: got %h want fc", v);
        end
        wr(2'd3, 32'hFFFF_FFFF);
        rd_reg(2'd3, v); n_chk++;
        if (v !== 32'h0) begin
            n_fail++; $display("FAIL stat_ro: got %h want 0", v);
        end
    endtask

    initial begin
        reset = 1'b1;
        sel = 1'b0; we = 1'b0; dev_addr = 2'd0; wd = 32'd0;
        hw_intr_in = 6'd0; intr_ack = 1'b0; eret = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_no_preempt();
        test_level();
        test_mask_drop();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
